simon_key_expand: RTL and testbench
===================================

// Module: simon_key_expand
// PURPOSE
//  Simon 32/64 key-schedule engine; answers the control FSM's key-generation states.
//  On start it latches the 64-bit master key and expands it to all 32 16-bit round keys, one per cycle.
//  It stores the round keys in an internal register file and raises key_done for the FSM.
//  The round datapath reads any round key by index, so decryption can walk the keys in reverse.
// PARAMETERS
//  WORD    16  round-key width n; only the default is supported
//  KWORDS  4   master-key words m; only the default is supported
//  ROUNDS  32  round keys generated T; only the default is supported
// PORTS
//  clk       in   1   clock; all state changes on the rising edge
//  res       in   1   reset, asynchronous, active-high
//  start     in   1   1-cycle request from the control FSM to expand key_in
//  key_in    in   64  master key {k3,k2,k1,k0}; k0 = key_in[15:0]
//  busy      out  1   high while in GEN
//  key_done  out  1   level; all ROUNDS keys valid; held until the next accepted start or reset
//  rk_idx    in   5   round-key read index 0..31
//  rk_out    out  16  registered read data: rk[rk_idx] sampled on the previous edge
// BEHAVIOUR
//  Reset (async assert, res=1): state=IDLE, busy=0, key_done=0, rk_out=0, cnt=0, all 32 rk entries=0.
//  States: IDLE, GEN, DONE.
//   IDLE --start--> GEN.
//   GEN --cnt==31 written--> DONE.
//   DONE --start--> GEN.
//  Start accept edge (IDLE or DONE, start=1):
//   - load rk[0..3] = key_in words; cnt=4; busy=1; key_done=0.
//  GEN, each edge: rk[cnt] = k_new; cnt++.
//  After the edge that writes rk[31]: state=DONE, busy=0, key_done=1.
//  Round-key function (cnt=i, i>=4):
//   - tmp   = ror3(rk[i-1]) ^ rk[i-3]
//   - k_new = rk[i-4] ^ tmp ^ ror1(tmp) ^ 16'hFFFC ^ {15'b0, z0[i-4]}
//  z0 = 62'b11111010001001010110000111001101111101000100101011000011100110
//   - z0[0] is the leftmost character of this literal
//   - i-4 <= 27, so the index never wraps
//  All arithmetic is XOR/rotate mod 2^16; there is no carry.
//  Latency: key_done is first seen high exactly 28 cycles after the start accept edge.
//  start during GEN is ignored: no reload, no change to cnt or timing.
//  start in DONE restarts: key_done falls on the accept edge; old keys are overwritten progressively.
//  key_in is sampled only on the accept edge; later changes have no effect.
//  Read port:
//   - rk_out <= rk[rk_idx] every edge in any state.
//   - Reading an index during GEN returns whatever is currently stored.
//   - When rk_idx names the entry being written on the same edge, rk_out returns the old value (no bypass).
//  Reset mid-GEN: immediate return to IDLE with all outputs at reset values; the next start begins a fresh expansion.
//  start while res=1 is ignored.
// TESTING
//  1 Assert res mid-cycle from any state -> busy=0, key_done=0 and rk_out=0 immediately, with no clock edge.
//  2 key_in=64'h1918_1110_0908_0100, pulse start:
//   - busy=1 on the next cycle; key_done=1 28 cycles after the accept edge.
//   - rk_idx=0..3 -> 0100, 0908, 1110, 1918; rk_idx=4 -> 16'h71C3.
//  3 Same key; compare rk[0..31] against a C golden Simon32/64 schedule.
//   - Then run the encryption path: plaintext 32'h6565_6877 -> ciphertext 32'hC69B_E9BB.
//  4 Pulse start again at cycle 10 of GEN with a different key_in -> ignored; keys and key_done timing identical to test 2.
//  5 In DONE, start with key_in=64'h0:
//   - key_done=0 after the accept edge; key_done=1 again 28 cycles later.
//   - rk[0..31] match the golden model for the zero key.
//  6 Assert res at cycle 15 of GEN, release, pulse start with the test-2 key -> full correct schedule in 28 cycles.

Source files
------------

// File: rtl/simon_key_expand.sv
// Simon 32/64 key-schedule engine: latches a 64-bit master key on start and
// expands it into 32 round keys, one per cycle, held in a readable register file.
module simon_key_expand #(
    parameter int WORD   = 16,
    parameter int KWORDS = 4,
    parameter int ROUNDS = 32
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    input  logic [WORD*KWORDS-1:0]   key_in,
    output logic                     busy,
    output logic                     key_done,
    input  logic [$clog2(ROUNDS)-1:0] rk_idx,
    output logic [WORD-1:0]          rk_out,
    output logic [1:0]               state_dbg
);

    localparam int IW = $clog2(ROUNDS);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GEN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // z0[0] is the leftmost bit of the literal, so sequence bit j lives at Z0[61-j].
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    // ~k ^ 3 folded into a single XOR constant.
    localparam logic [WORD-1:0] C_MASK = ~WORD'(3);

    localparam logic [IW-1:0] CNT_LOAD = IW'(KWORDS);
    localparam logic [IW-1:0] CNT_LAST = IW'(ROUNDS - 1);

    // Handshake: start is a single-cycle request sampled only in IDLE or DONE;
    // key_done is a level that stays high until the next accepted start or reset.

    logic [1:0]      state;
    logic [IW-1:0]   cnt;
    logic [WORD-1:0] rk [ROUNDS];

    logic [WORD-1:0] w_m1;
    logic [WORD-1:0] w_m3;
    logic [WORD-1:0] w_m4;
    logic [WORD-1:0] tmp;
    logic [WORD-1:0] k_new;
    logic [5:0]      z_idx;
    logic            z_bit;
    logic            accept;

    assign busy      = (state == ST_GEN);
    assign key_done  = (state == ST_DONE);
    assign state_dbg = state;
    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        w_m1  = rk[cnt - IW'(1)];
        w_m3  = rk[cnt - IW'(3)];
        w_m4  = rk[cnt - IW'(4)];
        z_idx = 6'd61 - 6'(cnt - IW'(4));
        z_bit = Z0[z_idx];
        tmp   = {w_m1[2:0], w_m1[WORD-1:3]} ^ w_m3;
        k_new = w_m4 ^ tmp ^ {tmp[0], tmp[WORD-1:1]} ^ C_MASK
              ^ {{(WORD-1){1'b0}}, z_bit};
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rk_out <= '0;
            for (int i = 0; i < ROUNDS; i++) begin
                rk[i] <= '0;
            end
        end else begin
            // Read before write: an entry written this edge still returns its old value.
            rk_out <= rk[rk_idx];
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        for (int j = 0; j < KWORDS; j++) begin
                            rk[j] <= key_in[j*WORD +: WORD];
                        end
                        cnt   <= CNT_LOAD;
                        state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    rk[cnt] <= k_new;
                    cnt     <= cnt + IW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_key_expand.sv
// Bench for simon_key_expand: known-answer table, golden schedule and encryption,
// restart/ignore/reset corner sequences, and random keys against a reference model.
module tb_simon_key_expand;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [63:0] key_in;
    logic        busy;
    logic        key_done;
    logic [4:0]  rk_idx;
    logic [15:0] rk_out;
    logic [1:0]  state_dbg;

    simon_key_expand dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_done  (key_done),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY_REF = 64'h1918_1110_0908_0100;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_rk [32];
    logic [15:0] old_rk [32];
    logic [15:0] dut_rk [32];
    logic [15:0] exp_q [$];

    typedef struct {
        logic [63:0] key;
        logic [4:0]  idx;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ror16(input int x, input int r);
        return ((x >> r) | (x << (16 - r))) & 'hFFFF;
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    // Reference schedule straight from the round-key recurrence.
    task automatic model_schedule(input logic [63:0] key);
        string z0 = "11111010001001010110000111001101111101000100101011000011100110";
        int    k [32];
        int    t;
        for (int i = 0; i < 4; i++) begin
            k[i] = int'(key[16*i +: 16]);
        end
        for (int i = 4; i < 32; i++) begin
            t    = ror16(k[i-1], 3) ^ k[i-3];
            k[i] = (k[i-4] ^ t ^ ror16(t, 1) ^ 'hFFFC ^ ((z0[i-4] == "1") ? 1 : 0)) & 'hFFFF;
        end
        for (int i = 0; i < 32; i++) begin
            exp_rk[i] = k[i][15:0];
        end
    endtask

    function automatic logic [31:0] simon_encrypt(input logic [31:0] pt);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ dut_rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Ends at the falling edge right after the accept edge (cycle 0).
    task automatic pulse_start(input logic [63:0] key);
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cycles);
        cycles = c0;
        while (!key_done && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic read_rk(input logic [4:0] idx, output logic [15:0] val);
        rk_idx = idx;
        @(negedge clk);
        val = rk_out;
    endtask

    task automatic do_expand(input string name, input logic [63:0] key);
        int cyc;
        model_schedule(key);
        pulse_start(key);
        check({name, "_busy"}, busy, 1'b1);
        wait_done(0, cyc);
        check({name, "_latency"}, cyc, 28);
    endtask

    task automatic check_schedule(input string name);
        logic [15:0] v;
        logic [15:0] e;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(exp_rk[i]);
        end
        for (int i = 0; i < 32; i++) begin
            read_rk(5'(i), v);
            dut_rk[i] = v;
            e = exp_q.pop_front();
            check($sformatf("%s_rk%0d", name, i), v, e);
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [63:0] rkey;
        int          n;

        // Reset state and start ignored under reset.
        res    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_idx = '0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", key_done, 1'b0);
        check("rst_rk_out", rk_out, 16'h0);
        @(negedge clk);
        key_in = KEY_REF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        res    = 1'b0;
        check("start_in_rst_busy", busy, 1'b0);
        @(negedge clk);
        check("start_in_rst_done", key_done, 1'b0);
        read_rk(5'd7, v);
        check("rst_rk7", v, 16'h0);

        // Known-answer table.
        vecs[0] = '{KEY_REF, 5'd0, 16'h0100};
        vecs[1] = '{KEY_REF, 5'd1, 16'h0908};
        vecs[2] = '{KEY_REF, 5'd2, 16'h1110};
        vecs[3] = '{KEY_REF, 5'd3, 16'h1918};
        vecs[4] = '{KEY_REF, 5'd4, 16'h71C3};
        vecs[5] = '{64'h0,   5'd4, 16'hFFFD};
        for (int i = 6; i < 8; i++) begin
            rkey = {$urandom, $urandom};
            model_schedule(rkey);
            vecs[i].key = rkey;
            vecs[i].idx = 5'($urandom_range(0, 31));
            vecs[i].exp = exp_rk[vecs[i].idx];
        end
        for (int i = 0; i < 8; i++) begin
            do_expand($sformatf("vec%0d", i), vecs[i].key);
            read_rk(vecs[i].idx, v);
            check($sformatf("vec%0d_rk", i), v, vecs[i].exp);
        end

        // Full golden schedule and encryption with the keys read back.
        do_expand("golden", KEY_REF);
        check_schedule("golden");
        check("encrypt", simon_encrypt(32'h6565_6877), 32'hC69B_E9BB);

        // start mid-GEN with another key is ignored.
        model_schedule(KEY_REF);
        pulse_start(KEY_REF);
        check("ign_busy", busy, 1'b1);
        repeat (10) @(negedge clk);
        key_in = 64'hDEAD_BEEF_0BAD_F00D;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(11, n);
        check("ign_latency", n, 28);
        check_schedule("ign");

        // Restart from DONE with the zero key; no-bypass read of the entry being written.
        old_rk = exp_rk;
        model_schedule(64'h0);
        pulse_start(64'h0);
        check("restart_done_low", key_done, 1'b0);
        n = 0;
        while (!key_done && n < 60) begin
            if (n == 16) rk_idx = 5'd20;
            if (n == 5) key_in = {$urandom, $urandom};
            @(negedge clk);
            n++;
            if (n == 17) check("no_bypass_old", rk_out, old_rk[20]);
            if (n == 18) check("no_bypass_new", rk_out, exp_rk[20]);
        end
        check("restart_latency", n, 28);
        check_schedule("zero");

        // Reset at cycle 15 of GEN, then a fresh expansion.
        model_schedule(KEY_REF);
        rk_idx = 5'd3;
        pulse_start(KEY_REF);
        repeat (15) @(negedge clk);
        #2 res = 1'b1;
        #1;
        check("midgen_rst_busy", busy, 1'b0);
        check("midgen_rst_done", key_done, 1'b0);
        check("midgen_rst_rk_out", rk_out, 16'h0);
        @(negedge clk);
        res = 1'b0;
        do_expand("after_rst", KEY_REF);
        check_schedule("after_rst");

        // Reset asserted from DONE.
        rk_idx = 5'd0;
        @(negedge clk);
        #2 res = 1'b1;
        #1;
        check("done_rst_busy", busy, 1'b0);
        check("done_rst_done", key_done, 1'b0);
        check("done_rst_rk_out", rk_out, 16'h0);
        @(negedge clk);
        res = 1'b0;

        // Random keys against the reference model.
        for (int r = 0; r < 5; r++) begin
            rkey = {$urandom, $urandom};
            do_expand($sformatf("rand%0d", r), rkey);
            check_schedule($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
